// File: rtl/fft8_bitrev_reorder.sv
// Ping-pong 8-point reorder buffer: natural-order samples in, bit-reversed order out.
// One bank fills while the other drains, so back-to-back frames stream out gapless.
module fft8_bitrev_reorder #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         en_in,
    input  logic                         clr_in,
    input  logic signed [DATA_WIDTH-1:0] src_data_in,
    input  logic                         src_valid_in,
    output logic signed [DATA_WIDTH-1:0] dst_data_out,
    output logic                         dst_valid_out,
    output logic                         dst_last_out
);

    logic signed [DATA_WIDTH-1:0] mem_q [2][8];

    logic [2:0]                   wr_idx_q, wr_idx_d;
    logic [2:0]                   rd_idx_q, rd_idx_d;
    logic                         wr_bank_q, wr_bank_d;
    logic                         rd_bank_q, rd_bank_d;
    logic [1:0]                   full_q, full_d;
    logic signed [DATA_WIDTH-1:0] data_q, data_d;
    logic                         valid_q, valid_d;
    logic                         last_q, last_d;
    logic                         wr_en;
    logic [2:0]                   rd_addr;

    assign rd_addr = {rd_idx_q[0], rd_idx_q[1], rd_idx_q[2]};

    always_comb begin
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        wr_en     = 1'b0;
        if (clr_in) begin
            wr_idx_d  = 3'd0;
            rd_idx_d  = 3'd0;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            full_d    = 2'b00;
        end else begin
            if (src_valid_in) begin
                wr_en    = 1'b1;
                wr_idx_d = wr_idx_q + 3'd1;
                if (wr_idx_q == 3'd7) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                end
            end
            // Write and read always target different banks, so set/clear never collide.
            if (full_q[rd_bank_q]) begin
                data_d   = mem_q[rd_bank_q][rd_addr];
                valid_d  = 1'b1;
                last_d   = (rd_idx_q == 3'd7);
                rd_idx_d = rd_idx_q + 3'd1;
                if (rd_idx_q == 3'd7) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                end
            end
        end
    end

    // Sample storage carries no reset; contents are only read once written.
    always_ff @(posedge clk) begin
        if (en_in && wr_en)
            mem_q[wr_bank_q][wr_idx_q] <= src_data_in;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_idx_q  <= 3'd0;
            rd_idx_q  <= 3'd0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= 2'b00;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else if (en_in) begin
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
        end
    end

    assign dst_data_out  = data_q;
    assign dst_valid_out = valid_q;
    assign dst_last_out  = last_q;

endmodule

// File: tb/tb_fft8_bitrev_reorder.sv
// Directed bench for the bit-reverse reorder buffer: captures every output produced
// on an active edge and compares the stream against hand-computed expected orders.
module tb_fft8_bitrev_reorder;

    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 arst_n = 1'b0;
    logic                 en_in = 1'b1;
    logic                 clr_in = 1'b0;
    logic signed [DW-1:0] src_data_in = '0;
    logic                 src_valid_in = 1'b0;
    logic signed [DW-1:0] dst_data_out;
    logic                 dst_valid_out;
    logic                 dst_last_out;

    fft8_bitrev_reorder #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .en_in        (en_in),
        .clr_in       (clr_in),
        .src_data_in  (src_data_in),
        .src_valid_in (src_valid_in),
        .dst_data_out (dst_data_out),
        .dst_valid_out(dst_valid_out),
        .dst_last_out (dst_last_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int viol   = 0;
    bit act    = 1'b0;
    int ord [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    int outq [$];
    int lastq[$];
    int cycq [$];
    int expq [$];
    int explq[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        act <= en_in && arst_n;
        if (arst_n && en_in && !clr_in && src_valid_in && dut.full_q[dut.wr_bank_q])
            viol <= viol + 1;
    end

    always @(negedge clk) begin
        if (act && dst_valid_out) begin
            outq.push_back(int'(dst_data_out));
            lastq.push_back(int'(dst_last_out));
            cycq.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic drive(input int v, input bit vld, input bit en = 1'b1, input bit clr = 1'b0);
        @(negedge clk);
        src_data_in  = DW'(v);
        src_valid_in = vld;
        en_in        = en;
        clr_in       = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 1'b0);
    endtask

    task automatic add_frame(input int base, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            expq.push_back(base + ord[k]);
            explq.push_back(int'(k == 7));
        end
    endtask

    task automatic cmp_stream(input string tag, input bit contig);
        chk($sformatf("%s_count", tag), outq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            chk($sformatf("%s_data[%0d]", tag, i), outq[i], expq[i]);
            chk($sformatf("%s_last[%0d]", tag, i), lastq[i], explq[i]);
            if (contig) chk($sformatf("%s_gap[%0d]", tag, i), cycq[i] - cycq[0], i);
        end
        outq.delete(); lastq.delete(); cycq.delete();
        expq.delete(); explq.delete();
    endtask

    initial begin
        int c7;

        #1;
        chk("rst_valid", int'(dst_valid_out), 0);
        chk("rst_last",  int'(dst_last_out), 0);
        chk("rst_data",  int'(dst_data_out), 0);
        @(negedge clk); @(negedge clk);
        arst_n = 1'b1;

        // One frame 10..17, check latency and hold after the frame.
        for (int i = 0; i < 8; i++) drive(10 + i, 1'b1);
        c7 = cyc;
        idle(12);
        chk("t1_latency", cycq.size() > 0 ? cycq[0] : -1, c7 + 2);
        chk("t1_hold_data",  int'(dst_data_out), 17);
        chk("t1_hold_valid", int'(dst_valid_out), 0);
        add_frame(10, 8);
        cmp_stream("t1", 1'b1);

        // Three back-to-back frames 0..23.
        for (int i = 0; i < 24; i++) drive(i, 1'b1);
        idle(12);
        add_frame(0, 8); add_frame(8, 8); add_frame(16, 8);
        cmp_stream("t2", 1'b1);

        // Sparse valid plus a 3-cycle freeze mid-read with junk presented.
        for (int i = 0; i < 8; i++) begin
            drive(10 + i, 1'b1);
            drive(0, 1'b0);
        end
        idle(2);
        for (int i = 0; i < 3; i++) drive(999, 1'b1, 1'b0);
        drive(0, 1'b0);
        chk("t3_frozen_data",  int'(dst_data_out), 12);
        chk("t3_frozen_valid", int'(dst_valid_out), 1);
        idle(12);
        add_frame(10, 8);
        cmp_stream("t3", 1'b0);

        // Partial frame discarded by an asynchronous reset pulse.
        for (int i = 0; i < 5; i++) drive(50 + i, 1'b1);
        idle(1);
        chk("t4_partial_quiet", outq.size(), 0);
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        chk("t4_rst_valid", int'(dst_valid_out), 0);
        chk("t4_rst_data",  int'(dst_data_out), 0);
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 8; i++) drive(100 + i, 1'b1);
        idle(12);
        add_frame(100, 8);
        cmp_stream("t4", 1'b1);

        // Clear at read index 3 while the next frame is half written.
        for (int i = 0; i < 8; i++) drive(200 + i, 1'b1);
        for (int i = 0; i < 3; i++) drive(210 + i, 1'b1);
        drive(213, 1'b1, 1'b1, 1'b1);
        drive(0, 1'b0);
        chk("t5_clr_valid", int'(dst_valid_out), 0);
        chk("t5_clr_last",  int'(dst_last_out), 0);
        for (int i = 0; i < 8; i++) drive(220 + i, 1'b1);
        idle(12);
        add_frame(200, 3);
        add_frame(220, 8);
        cmp_stream("t5", 1'b0);

        // Full-scale corners at every position.
        drive(-32768, 1'b1); drive(32767, 1'b1); drive(0, 1'b1);     drive(-1, 1'b1);
        drive(1, 1'b1);      drive(-32767, 1'b1); drive(32766, 1'b1); drive(-2, 1'b1);
        idle(12);
        expq.push_back(-32768); expq.push_back(1);      expq.push_back(0);  expq.push_back(32766);
        expq.push_back(32767);  expq.push_back(-32767); expq.push_back(-1); expq.push_back(-2);
        for (int k = 0; k < 8; k++) explq.push_back(int'(k == 7));
        cmp_stream("t6", 1'b1);

        chk("full_bank_write", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft8_bitrev_reorder.md
FFT8_BITREV_REORDER -- requirements
Module: fft8_bitrev_reorder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning signed sample width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, meaning clock (all state changes on rising edge).
REQ-003 The block SHALL have port arst_n, input, 1 bit, meaning reset (asynchronous, active-low).
REQ-004 The block SHALL have port en_in, input, 1 bit, meaning global enable; low freezes all state.
REQ-005 The block SHALL have port clr_in, input, 1 bit, meaning synchronous frame clear, honoured only when en_in=1.
REQ-006 The block SHALL have port src_data_in, input, signed DATA_WIDTH bits, meaning natural-order input sample.
REQ-007 The block SHALL have port src_valid_in, input, 1 bit, meaning src_data_in is valid this cycle.
REQ-008 The block SHALL have port dst_data_out, output, signed DATA_WIDTH bits, meaning bit-reversed-order sample to the FFT pipeline.
REQ-009 The block SHALL have port dst_valid_out, output, 1 bit, meaning dst_data_out is valid.
REQ-010 The block SHALL have port dst_last_out, output, 1 bit, meaning the current output is sample 7 of a frame.

Function
REQ-011 An "active edge" SHALL be a rising clk edge with en_in=1; no register SHALL change on any other edge, except through reset.
REQ-012 The block SHALL hold two 8-entry banks (ping-pong), a 3-bit write index, a write-bank pointer, a 3-bit read index, a read-bank pointer and one full flag per bank.
REQ-013 On an active edge with src_valid_in=1, the block SHALL write src_data_in to write_bank[write_index] and then increment write_index modulo 8.
REQ-014 The write that uses write_index=7 SHALL set that bank's full flag and toggle the write-bank pointer.
REQ-015 On an active edge where the read bank is full, the block SHALL load the output register with read_bank[bitrev3(read_index)], where bitrev3 reverses the 3 index bits, set dst_valid_out=1, and increment read_index modulo 8.
REQ-016 The output order within a frame SHALL be natural indices 0,4,2,6,1,5,3,7.
REQ-017 dst_last_out SHALL be 1 only together with the output taken at read_index=7; that read SHALL clear the bank's full flag and toggle the read-bank pointer.
REQ-018 On an active edge where the read bank is not full, dst_valid_out and dst_last_out SHALL be 0, and dst_data_out SHALL hold its previous value.
REQ-019 Latency: the first output of a frame SHALL be registered on the first active edge after the edge that wrote sample 7.
REQ-020 When samples arrive back-to-back, the output stream SHALL be gapless: frame N+1 index 0 follows frame N index 7 on the next active edge.
REQ-021 A write to one bank and a read or clear of the other bank on the same edge SHALL both take effect.
REQ-022 A bank SHALL never be written while its full flag is set; with one write per edge and 8 reads per frame this cannot occur, and the verifier SHALL assert it never does.
REQ-023 A partial frame (fewer than 8 samples) SHALL produce no output until completed.
REQ-024 When clr_in=1 on an active edge, the block SHALL zero both indices, both pointers, both full flags, dst_valid_out and dst_last_out; clr_in SHALL override any simultaneous write or read.
REQ-025 Bank contents SHALL not be reset and SHALL not be observable before they are written.

Reset
REQ-026 When arst_n=0, the block SHALL immediately clear the indices, pointers and full flags, and drive dst_data_out=0, dst_valid_out=0 and dst_last_out=0.
REQ-027 Reset asserted mid-frame SHALL discard all buffered samples; the first valid sample after release SHALL be index 0 of a new frame.

Verification
REQ-028 Reset then 8 consecutive valid samples 10..17 -> starting the next cycle, outputs 10,14,12,16,11,15,13,17 with valid high for 8 cycles and last high on 17 only.
REQ-029 24 back-to-back samples 0..23 -> 24 contiguous valid outputs, frames reordered as 0,4,2,6,1,5,3,7 / 8,12,10,14,9,13,11,15 / 16,...,23, with no valid gap.
REQ-030 Samples with src_valid_in toggling 1,0,1,0 and en_in low for 3 cycles mid-read -> same ordered values as REQ-028, all state frozen while en_in=0, no spurious valid.
REQ-031 5 samples, then arst_n pulse, then 8 samples 100..107 -> output 100,104,102,106,101,105,103,107 only; the pre-reset samples never appear.
REQ-032 clr_in asserted at read_index=3 while the next frame is half written -> valid drops the next cycle; a following full frame outputs correctly from index 0.
REQ-033 Width corners with DATA_WIDTH=16: samples -32768 and 32767 -> reproduced bit-exact at their bit-reversed positions.
